mult_pipe: RTL and testbench

Parametrised, pipelined signed multiplier with argument parity checking and an output result queue; the next generation of the 16×16 parity-checked multiplier. It keeps the req/ack argument handshake and the result/result_parity/arg_parity_error/result_rdy output set. It adds configurable operand width, a fixed-latency multiplier pipeline, several operations in flight, and consumer back-pressure through `result_ack`. It sits between the test/command side and the result consumer in place of the fixed 16-bit multiplier.

---
 rtl/mult_pkg.sv | 26 ++
 rtl/mult_pipe_fifo.sv | 55 +++++
 rtl/mult_pipe.sv | 188 ++++++++++++++++++
 tb/tb_mult_pipe.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// mult_pkg: shared definitions for the pipelined parity-checked multiplier.
//   DEF_WIDTH / DEF_STAGES / DEF_FIFO_DEPTH : default parameter values
//   PAR_W   : width of the parity helper argument (operands are zero-extended)
//   state_t : argument handshake FSM states
//   parity(): even-parity bit of a zero-extended vector
package mult_pkg;

  localparam int DEF_WIDTH      = 16;
  localparam int DEF_STAGES     = 3;
  localparam int DEF_FIFO_DEPTH = 4;

  // Large enough for a 2*WIDTH result with WIDTH up to 127.
  localparam int PAR_W = 256;

  typedef enum logic {
    IDLE,
    ACK
  } state_t;

  // Zero padding does not change the XOR reduction, so callers widen
  // their value with zeros (never sign-extend) before calling.
  function automatic logic parity(input logic [PAR_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/mult_pipe_fifo.sv
// mult_pipe_fifo: synchronous first-word-fall-through FIFO.
//   clk, rst_n : clock and asynchronous active-low reset (pointers only)
//   push, din  : write request and data
//   pop        : read request; advances the head when non-empty
//   dout       : current head entry (valid while empty=0)
//   empty/full : occupancy flags
module mult_pipe_fifo #(
  parameter int DW    = 34,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic [DW-1:0] dout,
  output logic          empty,
  output logic          full
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          do_push;
  logic          do_pop;

  // A simultaneous pop frees the slot being written, so push is allowed
  // when full only if the head leaves on the same edge.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/mult_pipe.sv
// mult_pipe: pipelined signed WIDTH x WIDTH multiplier with operand parity
// checking, req/ack argument handshake and a credit-protected result queue.
//   clk, rst_n        : clock, asynchronous active-low reset
//   arg_a/arg_b       : signed operands, each with an even-parity bit
//   req / ack         : request held until the one-cycle ack pulse
//   result            : signed 2*WIDTH product at the queue head (0 if empty)
//   result_parity     : parity of result
//   result_rdy        : queue non-empty
//   arg_parity_error  : head entry came from a request with bad parity
//   result_ack        : consumer pops the head when result_rdy=1
module mult_pipe
  import mult_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int STAGES     = DEF_STAGES,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic signed [WIDTH-1:0]   arg_a,
  input  logic                      arg_a_parity,
  input  logic signed [WIDTH-1:0]   arg_b,
  input  logic                      arg_b_parity,
  input  logic                      req,
  output logic                      ack,
  output logic signed [2*WIDTH-1:0] result,
  output logic                      result_parity,
  output logic                      result_rdy,
  output logic                      arg_parity_error,
  input  logic                      result_ack
);

  localparam int RW = 2 * WIDTH;
  localparam int EW = RW + 2;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  // Queue entry layout: {arg_parity_error, result_parity, result}.

  function automatic logic [PAR_W-1:0] widen_arg(input logic [WIDTH-1:0] d);
    return {{(PAR_W-WIDTH){1'b0}}, d};
  endfunction

  function automatic logic [PAR_W-1:0] widen_res(input logic [RW-1:0] d);
    return {{(PAR_W-RW){1'b0}}, d};
  endfunction

  function automatic logic [EW-1:0] make_entry(input logic signed [WIDTH-1:0] a,
                                               input logic signed [WIDTH-1:0] b,
                                               input logic                    err);
    logic signed [RW-1:0] p;
    p = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});
    if (err) begin
      return {1'b1, 1'b0, {RW{1'b0}}};
    end
    return {1'b0, parity(widen_res(p)), p};
  endfunction

  state_t               state;
  state_t               state_nxt;
  logic                 accept;
  logic                 pop;
  logic                 credit;
  logic [CW-1:0]        used;

  logic signed [WIDTH-1:0] a_p0;
  logic signed [WIDTH-1:0] b_p0;
  logic                    err_p0;
  logic                    vld_p0;
  logic [EW-1:0]           ent_p0;

  logic                 push;
  logic [EW-1:0]        push_ent;
  logic [EW-1:0]        fifo_head;
  logic                 fifo_empty;
  logic                 fifo_full_unused;

  // Every accepted op owns a queue slot from acceptance until it is popped,
  // so the pipeline can never deliver into a full queue.
  assign credit = (used < CW'(FIFO_DEPTH));
  assign pop    = result_ack && !fifo_empty;
  assign ack    = (state == ACK);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (req && credit) begin
          accept    = 1'b1;
          state_nxt = ACK;
        end
      end
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      used <= '0;
    end else begin
      case ({accept, pop})
        2'b10:   used <= used + CW'(1);
        2'b01:   used <= used - CW'(1);
        default: used <= used;
      endcase
    end
  end

  // ---- stage p0: operand capture on acceptance ----
  always_ff @(posedge clk) begin
    if (accept) begin
      a_p0   <= arg_a;
      b_p0   <= arg_b;
      err_p0 <= (arg_a_parity != parity(widen_arg(arg_a))) ||
                (arg_b_parity != parity(widen_arg(arg_b)));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0 <= 1'b0;
    end else begin
      vld_p0 <= accept;
    end
  end

  assign ent_p0 = make_entry(a_p0, b_p0, err_p0);

  // ---- stages p1..p(STAGES-1): product/flag shift; the last feeds the queue ----
  if (STAGES == 1) begin : g_direct
    assign push     = vld_p0;
    assign push_ent = ent_p0;
  end else begin : g_pipe
    logic [STAGES-1:1][EW-1:0] ent_p;
    logic [STAGES-1:1]         vld_p;

    always_ff @(posedge clk) begin
      ent_p[1] <= ent_p0;
      for (int s = 2; s < STAGES; s++) begin
        ent_p[s] <= ent_p[s-1];
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_p <= '0;
      end else begin
        vld_p[1] <= vld_p0;
        for (int s = 2; s < STAGES; s++) begin
          vld_p[s] <= vld_p[s-1];
        end
      end
    end

    assign push     = vld_p[STAGES-1];
    assign push_ent = ent_p[STAGES-1];
  end

  // ---- result queue ----
  mult_pipe_fifo #(
    .DW    (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (push_ent),
    .pop   (pop),
    .dout  (fifo_head),
    .empty (fifo_empty),
    .full  (fifo_full_unused)
  );

  assign result_rdy       = !fifo_empty;
  assign result           = fifo_empty ? '0 : $signed(fifo_head[RW-1:0]);
  assign result_parity    = fifo_empty ? 1'b0 : fifo_head[RW];
  assign arg_parity_error = fifo_empty ? 1'b0 : fifo_head[RW+1];

endmodule

// File: tb/tb_mult_pipe.sv
// tb_mult_pipe: directed, scoreboard-based bench for mult_pipe
// (WIDTH=16, STAGES=3, FIFO_DEPTH=4). Inputs change 1 time unit after the
// rising edge; outputs are sampled at the same point.
module tb_mult_pipe;

  localparam int W  = 16;
  localparam int ST = 3;
  localparam int FD = 4;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [W-1:0]        arg_a = '0;
  logic                arg_a_parity = 1'b0;
  logic [W-1:0]        arg_b = '0;
  logic                arg_b_parity = 1'b0;
  logic                req = 1'b0;
  logic                ack;
  logic [2*W-1:0]      result;
  logic                result_parity;
  logic                result_rdy;
  logic                arg_parity_error;
  logic                result_ack = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [2*W+1:0] sb [$];

  mult_pipe #(
    .WIDTH      (W),
    .STAGES     (ST),
    .FIFO_DEPTH (FD)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .arg_a            (arg_a),
    .arg_a_parity     (arg_a_parity),
    .arg_b            (arg_b),
    .arg_b_parity     (arg_b_parity),
    .req              (req),
    .ack              (ack),
    .result           (result),
    .result_parity    (result_parity),
    .result_rdy       (result_rdy),
    .arg_parity_error (arg_parity_error),
    .result_ack       (result_ack)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // Expected {arg_parity_error, result_parity, result} for one request.
  function automatic logic [2*W+1:0] model(input logic [W-1:0] a, input logic ap,
                                           input logic [W-1:0] b, input logic bp);
    int          sa;
    int          sbv;
    logic [31:0] p;
    if ((ap !== ^a) || (bp !== ^b)) begin
      return {1'b1, 1'b0, 32'h0};
    end
    sa  = int'($signed(a));
    sbv = int'($signed(b));
    p   = sa * sbv;
    return {1'b0, ^p, p};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_ack"},    64'(ack), 64'(0));
    check({tag, "_result"}, 64'(result), 64'(0));
    check({tag, "_rpar"},   64'(result_parity), 64'(0));
    check({tag, "_rdy"},    64'(result_rdy), 64'(0));
    check({tag, "_perr"},   64'(arg_parity_error), 64'(0));
  endtask

  // Raise req with the given operands and wait (bounded) for ack.
  task automatic do_op(input logic [W-1:0] a, input logic ap,
                       input logic [W-1:0] b, input logic bp, input string tag);
    logic got;
    int   n;
    got = 1'b0;
    n   = 0;
    arg_a = a; arg_a_parity = ap;
    arg_b = b; arg_b_parity = bp;
    req = 1'b1;
    while (!got && n < 20) begin
      tick();
      n++;
      if (ack) got = 1'b1;
    end
    check({tag, "_ack"}, 64'(got), 64'(1));
    if (got) sb.push_back(model(a, ap, b, bp));
    req = 1'b0;
  endtask

  // Wait (bounded) for a head entry, compare against the scoreboard, pop it.
  task automatic pop_check(input string tag);
    int             n;
    logic [2*W+1:0] exp;
    n = 0;
    while (!result_rdy && n < 10) begin
      tick();
      n++;
    end
    check({tag, "_rdy"}, 64'(result_rdy), 64'(1));
    if (result_rdy) begin
      if (sb.size() > 0) begin
        exp = sb.pop_front();
        check({tag, "_entry"}, 64'({arg_parity_error, result_parity, result}), 64'(exp));
      end else begin
        check({tag, "_sbsize"}, 64'(sb.size()), 64'(1));
      end
      result_ack = 1'b1;
      tick();
      result_ack = 1'b0;
    end
  endtask

  // Single op into an empty queue: checks the exact STAGES-edge latency.
  task automatic latency_op(input logic [W-1:0] a, input logic ap,
                            input logic [W-1:0] b, input logic bp, input string tag);
    do_op(a, ap, b, bp, tag);
    check({tag, "_lat0"}, 64'(result_rdy), 64'(0));
    tick();
    check({tag, "_lat1"}, 64'(result_rdy), 64'(0));
    tick();
    check({tag, "_lat2"}, 64'(result_rdy), 64'(0));
    tick();
    check({tag, "_lat3"}, 64'(result_rdy), 64'(1));
    pop_check(tag);
    check({tag, "_drained"}, 64'(result_rdy), 64'(0));
  endtask

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         ack_seen;
    int           stale;

    // Reset
    rst_n = 1'b0;
    repeat (3) tick();
    check_outputs_zero("rst");
    rst_n = 1'b1;
    repeat (3) tick();
    check_outputs_zero("post_rst");

    // Single valid op, parity error, extremes
    latency_op(16'hFFFD, 1'b1, 16'h0007, 1'b1, "valid");
    latency_op(16'h0005, 1'b1, 16'h0002, 1'b1, "perr");
    latency_op(16'h8000, 1'b1, 16'h8000, 1'b1, "minmin");
    latency_op(16'h7FFF, 1'b1, 16'h8000, 1'b1, "maxmin");

    // Back-pressure: four ops fill the credit, the fifth must wait.
    for (int i = 0; i < 4; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      do_op(ra, ^ra, rb, ^rb, "bp_fill");
    end
    ra = 16'h1234;
    rb = 16'hFEDC;
    arg_a = ra; arg_a_parity = ^ra;
    arg_b = rb; arg_b_parity = ^rb;
    req = 1'b1;
    ack_seen = 1'b0;
    repeat (6) begin
      tick();
      if (ack) ack_seen = 1'b1;
    end
    check("bp_blocked", 64'(ack_seen), 64'(0));
    check("bp_full_rdy", 64'(result_rdy), 64'(1));
    pop_check("bp_pop0");
    tick();
    check("bp_ack5", 64'(ack), 64'(1));
    if (ack) sb.push_back(model(ra, ^ra, rb, ^rb));
    req = 1'b0;
    pop_check("bp_pop1");
    pop_check("bp_pop2");
    pop_check("bp_pop3");
    pop_check("bp_pop4");
    check("bp_drained", 64'(result_rdy), 64'(0));

    // Reset mid-flight: one queued, two in the pipeline.
    do_op(16'h0011, ^16'h0011, 16'h0022, ^16'h0022, "mid_q");
    repeat (4) tick();
    do_op(16'h0033, ^16'h0033, 16'h0044, ^16'h0044, "mid_f1");
    do_op(16'h0055, ^16'h0055, 16'h0066, ^16'h0066, "mid_f2");
    check("mid_pre_rdy", 64'(result_rdy), 64'(1));
    rst_n = 1'b0;
    #1;
    check_outputs_zero("mid_rst");
    sb.delete();

    // req held through release is accepted on the first edge afterwards.
    ra = 16'h00FF;
    rb = 16'hFF00;
    arg_a = ra; arg_a_parity = ^ra;
    arg_b = rb; arg_b_parity = ^rb;
    req = 1'b1;
    repeat (2) tick();
    check("mid_hold_ack", 64'(ack), 64'(0));
    rst_n = 1'b1;
    tick();
    check("rel_ack", 64'(ack), 64'(1));
    if (ack) sb.push_back(model(ra, ^ra, rb, ^rb));
    req = 1'b0;
    check("rel_lat0", 64'(result_rdy), 64'(0));
    tick();
    check("rel_lat1", 64'(result_rdy), 64'(0));
    tick();
    check("rel_lat2", 64'(result_rdy), 64'(0));
    tick();
    check("rel_lat3", 64'(result_rdy), 64'(1));
    pop_check("rel_pop");
    stale = 0;
    repeat (8) begin
      tick();
      if (result_rdy) stale++;
    end
    check("rel_no_stale", 64'(stale), 64'(0));
    check("sb_empty", 64'(sb.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
